// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: 2-bit direction
// counter encoding, its training rule and the fresh-allocation value.
package btb_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strong not taken
    CTR_WNT = 2'b01,  // weak not taken
    CTR_WT  = 2'b10,  // weak taken
    CTR_ST  = 2'b11   // strong taken
  } ctr_e;

  // Direction prediction carried by a counter value.
  function automatic logic ctr_predict(input ctr_e ctr);
    return (ctr == CTR_WT) || (ctr == CTR_ST);
  endfunction

  // Training step for an existing entry. A jump always saturates to strong
  // taken. Taken from weak NT goes straight to strong T, and not taken from
  // anything but strong T collapses to strong NT.
  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken, input logic jump);
    ctr_e nxt;
    nxt = ctr;
    if (jump) begin
      nxt = CTR_ST;
    end else if (taken) begin
      case (ctr)
        CTR_SNT: nxt = CTR_WNT;
        default: nxt = CTR_ST;
      endcase
    end else begin
      case (ctr)
        CTR_ST:  nxt = CTR_WT;
        default: nxt = CTR_SNT;
      endcase
    end
    return nxt;
  endfunction

  // Counter value written into a freshly allocated entry.
  function automatic ctr_e ctr_init(input logic taken, input logic jump);
    ctr_e init;
    if (jump)       init = CTR_ST;
    else if (taken) init = CTR_WT;
    else            init = CTR_WNT;
    return init;
  endfunction

endpackage

// File: rtl/btb_entry.sv
// One BTB entry: valid, full-PC tag, target, direction counter and LRU age.
// The top broadcasts the update and tells each entry its role (hit, allocate,
// victim); the entry works out its own next state from that.
module btb_entry
  import btb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned AGE_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              upd_en_i,      // update accepted this cycle (not flushed)
  input  logic              upd_hit_i,     // update PC matched some entry
  input  logic              hit_sel_i,     // this entry is the matching one
  input  logic              alloc_sel_i,   // this entry is the lowest free slot
  input  logic              victim_sel_i,  // this entry is the LRU victim
  input  logic              upd_taken_i,   // effective direction (jump folded in)
  input  logic              upd_jump_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic [AGE_W-1:0]  ref_age_i,     // age of the hit entry before update
  output logic              valid_o,
  output logic [ADDR_W-1:0] tag_o,
  output logic [ADDR_W-1:0] target_o,
  output ctr_e              ctr_o,
  output logic [AGE_W-1:0]  age_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] target;
    ctr_e              ctr;
    logic [AGE_W-1:0]  age;
  } entry_t;

  entry_t entry_q, entry_d;

  // Next-state: flush, then train-on-hit, age shuffle, or (re)allocation.
  always_comb begin
    // NOTE: start from the held value so every path assigns entry_d; no latch.
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid = 1'b0;
      entry_d.age   = '0;
    end else if (upd_en_i) begin
      if (upd_hit_i) begin
        if (hit_sel_i) begin
          entry_d.ctr = ctr_next(entry_q.ctr, upd_taken_i, upd_jump_i);
          if (upd_taken_i) entry_d.target = upd_target_i;
          entry_d.age = '0;
        end else if (entry_q.valid && (entry_q.age < ref_age_i)) begin
          entry_d.age = entry_q.age + AGE_W'(1);
        end
      end else if (alloc_sel_i || victim_sel_i) begin
        entry_d.valid  = 1'b1;
        entry_d.tag    = upd_pc_i;
        entry_d.target = upd_target_i;
        entry_d.ctr    = ctr_init(upd_taken_i, upd_jump_i);
        entry_d.age    = '0;
      end else if (entry_q.valid) begin
        entry_d.age = entry_q.age + AGE_W'(1);
      end
    end
  end

  // Entry state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every field is cleared, not just valid, so the lookup mux and
      // the statistics never see X from an entry that was never written.
      entry_q <= '0;
    end else begin
      // NOTE: non-blocking so all entries sample the same pre-update ages.
      entry_q <= entry_d;
    end
  end

  assign valid_o  = entry_q.valid;
  assign tag_o    = entry_q.tag;
  assign target_o = entry_q.target;
  assign ctr_o    = entry_q.ctr;
  assign age_o    = entry_q.age;

endmodule

// File: rtl/btb_lru_cache.sv
// Fully associative branch target buffer with exact-age LRU replacement.
// Lookup is combinational on the registered entries; updates from execute
// land on the next edge. Saturating lookup/hit/mispredict statistics.
module btb_lru_cache
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned AGE_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic              lk_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_jump,
  input  logic [ADDR_W-1:0] upd_target,
  output logic [CNT_W-1:0]  stat_lookups,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_mispred
);

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] tag    [DEPTH];
  logic [ADDR_W-1:0] target [DEPTH];
  ctr_e              ctr    [DEPTH];
  logic [AGE_W-1:0]  age    [DEPTH];

  logic [DEPTH-1:0]  lk_match, upd_match, alloc_sel, victim_sel;
  logic [AGE_W-1:0]  lk_idx, upd_idx, free_idx, ref_age;
  logic              lk_hit, upd_hit, full, upd_en, taken_eff, mispredict;

  logic [CNT_W-1:0]  lookups_q, lookups_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic [CNT_W-1:0]  mispred_q, mispred_d;

  // Matches are guaranteed one-hot at most, so OR-ing indices encodes them.
  function automatic logic [AGE_W-1:0] onehot_to_idx(input logic [DEPTH-1:0] oh);
    logic [AGE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oh[i]) idx = idx | AGE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Tag compare for both the fetch lookup and the execute update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i]  = valid[i] && (tag[i] == lk_pc);
      upd_match[i] = valid[i] && (tag[i] == upd_pc);
    end
  end

  // Lowest-index invalid entry; full when every entry is valid.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = AGE_W'(i);
    end
  end

  assign full = &valid;

  // Per-entry role selects for a missing update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      alloc_sel[i]  = !full && (free_idx == AGE_W'(i));
      victim_sel[i] = full && (age[i] == AGE_W'(DEPTH - 1));
    end
  end

  // Fetch-side prediction from the registered entries.
  always_comb begin
    lk_hit      = |lk_match;
    lk_idx      = onehot_to_idx(lk_match);
    pred_hit    = lk_hit;
    pred_taken  = lk_hit && ctr_predict(ctr[lk_idx]);
    pred_target = lk_hit ? target[lk_idx] : '0;
  end

  // Execute-side hit, reference age and mispredict on pre-update state.
  always_comb begin
    upd_hit   = |upd_match;
    upd_idx   = onehot_to_idx(upd_match);
    ref_age   = age[upd_idx];
    taken_eff = upd_taken || upd_jump;
    upd_en    = upd_valid && !flush;
    if (upd_hit) begin
      mispredict = (ctr_predict(ctr[upd_idx]) != taken_eff) ||
                   (taken_eff && (target[upd_idx] != upd_target));
    end else begin
      mispredict = taken_eff;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    btb_entry #(
      .ADDR_W (ADDR_W),
      .AGE_W  (AGE_W)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .upd_en_i     (upd_en),
      .upd_hit_i    (upd_hit),
      .hit_sel_i    (upd_match[g]),
      .alloc_sel_i  (alloc_sel[g]),
      .victim_sel_i (victim_sel[g]),
      .upd_taken_i  (taken_eff),
      .upd_jump_i   (upd_jump),
      .upd_pc_i     (upd_pc),
      .upd_target_i (upd_target),
      .ref_age_i    (ref_age),
      .valid_o      (valid[g]),
      .tag_o        (tag[g]),
      .target_o     (target[g]),
      .ctr_o        (ctr[g]),
      .age_o        (age[g])
    );
  end

  // Saturating statistics next-state. A resolved branch counts toward
  // mispredicts even when a flush drops its allocation.
  always_comb begin
    lookups_d = sat_inc(lookups_q, lk_valid);
    hits_d    = sat_inc(hits_q, lk_valid && lk_hit);
    mispred_d = sat_inc(mispred_q, upd_valid && mispredict);
  end

  // Statistics registers; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
  assign stat_mispred = mispred_q;

  a_lk_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(lk_match));
  a_upd_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(upd_match));

endmodule

// File: tb/tb_btb_lru_cache.sv
// Directed bench for btb_lru_cache (DEPTH=4). Two instances share stimulus:
// one with 16-bit statistics and one with 2-bit statistics for saturation.
// A behavioural model (entry arrays plus an MRU-first recency queue) is
// checked against both DUTs every falling edge; literal checks pin the model.
module tb_btb_lru_cache;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        lk_valid = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_jump = 1'b0;
  logic [31:0] upd_target = '0;

  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [15:0] st_lookups, st_hits, st_mispred;
  logic        ps_hit, ps_taken;
  logic [31:0] ps_target;
  logic [1:0]  ss_lookups, ss_hits, ss_mispred;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  btb_lru_cache #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .lk_pc(lk_pc), .lk_valid(lk_valid),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .upd_target(upd_target), .stat_lookups(st_lookups), .stat_hits(st_hits),
    .stat_mispred(st_mispred)
  );

  btb_lru_cache #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .lk_pc(lk_pc), .lk_valid(lk_valid),
    .pred_hit(ps_hit), .pred_taken(ps_taken), .pred_target(ps_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .upd_target(upd_target), .stat_lookups(ss_lookups), .stat_hits(ss_hits),
    .stat_mispred(ss_mispred)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          lru[$];            // entry indices, most recently used first
  longint      n_lookups = 0, n_hits = 0, n_mispred = 0;

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  // Counter transition table: 0=SNT 1=WNT 2=WT 3=ST.
  function automatic int train(input int c, input bit tk);
    if (tk) begin
      case (c)
        0:       return 1;
        default: return 3;
      endcase
    end else begin
      case (c)
        3:       return 2;
        default: return 0;
      endcase
    end
  endfunction

  function automatic logic [63:0] sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic touch(input int h);
    for (int i = 0; i < lru.size(); i++) begin
      if (lru[i] == h) begin
        lru.delete(i);
        break;
      end
    end
    lru.push_front(h);
  endtask

  task automatic model_step();
    int  h, f;
    bit  teff;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      lru.delete();
      n_lookups = 0; n_hits = 0; n_mispred = 0;
      return;
    end
    if (lk_valid) begin
      n_lookups++;
      if (m_find(lk_pc) >= 0) n_hits++;
    end
    if (upd_valid) begin
      teff = upd_taken | upd_jump;
      h = m_find(upd_pc);
      if (h >= 0) begin
        if (((m_ctr[h] >= 2) != teff) || (teff && m_tgt[h] != upd_target)) n_mispred++;
      end else if (teff) begin
        n_mispred++;
      end
      if (!flush) begin
        if (h >= 0) begin
          m_ctr[h] = upd_jump ? 3 : train(m_ctr[h], teff);
          if (teff) m_tgt[h] = upd_target;
          touch(h);
        end else begin
          f = -1;
          for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) f = i;
          if (f < 0) begin
            f = lru[$];
            lru.pop_back();
          end
          m_valid[f] = 1'b1;
          m_tag[f]   = upd_pc;
          m_tgt[f]   = upd_target;
          m_ctr[f]   = upd_jump ? 3 : (upd_taken ? 2 : 1);
          lru.push_front(f);
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      lru.delete();
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // Compare both DUTs against the model in the middle of every cycle.
  always @(negedge clk) begin
    int h;
    if (chk_en) begin
      h = m_find(lk_pc);
      check("cmp.pred_hit",     pred_hit,    h >= 0);
      check("cmp.pred_taken",   pred_taken,  (h >= 0) ? (m_ctr[h] >= 2) : 1'b0);
      check("cmp.pred_target",  pred_target, (h >= 0) ? m_tgt[h] : 32'h0);
      check("cmp.s_pred_hit",   ps_hit,      h >= 0);
      check("cmp.s_pred_target", ps_target,  (h >= 0) ? m_tgt[h] : 32'h0);
      check("cmp.lookups",      st_lookups,  sat(n_lookups, 16));
      check("cmp.hits",         st_hits,     sat(n_hits, 16));
      check("cmp.mispred",      st_mispred,  sat(n_mispred, 16));
      check("cmp.s_lookups",    ss_lookups,  sat(n_lookups, 2));
      check("cmp.s_hits",       ss_hits,     sat(n_hits, 2));
      check("cmp.s_mispred",    ss_mispred,  sat(n_mispred, 2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic jp,
                        input logic [31:0] tgt, input logic fl);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_jump = jp;
    upd_target = tgt; flush = fl;
    step();
    upd_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] etg);
    lk_pc = pc; lk_valid = 1'b1;
    #1;
    check({name, ".hit"},    pred_hit,    eh);
    check({name, ".taken"},  pred_taken,  et);
    check({name, ".target"}, pred_target, etg);
    step();
    lk_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Reset state
    check("rst.lookups", st_lookups, 0);
    check("rst.mispred", st_mispred, 0);
    lookup("rst.look", 32'h100, 0, 0, 0);

    // Cold fill: four taken misses, each a mispredict, counters start at WT
    for (int i = 0; i < 4; i++) update(32'h100 + 4 * i, 1, 0, 32'h200 + i, 0);
    check("fill.mispred", st_mispred, 4);
    lookup("fill.100", 32'h100, 1, 1, 32'h200);
    lookup("fill.10C", 32'h10C, 1, 1, 32'h203);

    // LRU: touch 0x100, then a miss evicts 0x104 (oldest)
    update(32'h100, 1, 0, 32'h200, 0);
    check("lru.hit_upd_mispred", st_mispred, 4);
    update(32'h300, 1, 0, 32'h400, 0);
    check("lru.miss_mispred", st_mispred, 5);
    lookup("lru.104", 32'h104, 0, 0, 0);
    lookup("lru.100", 32'h100, 1, 1, 32'h200);
    lookup("lru.300", 32'h300, 1, 1, 32'h400);
    lookup("lru.108", 32'h108, 1, 1, 32'h202);
    lookup("lru.10C", 32'h10C, 1, 1, 32'h203);

    // Counter walk on 0x300 from WT: NT, NT, T, T.
    // Weak NT still predicts not taken, so the second taken also mispredicts.
    update(32'h300, 0, 0, 32'h400, 0);
    check("walk.nt1_mispred", st_mispred, 6);
    lookup("walk.nt1", 32'h300, 1, 0, 32'h400);
    update(32'h300, 0, 0, 32'h400, 0);
    check("walk.nt2_mispred", st_mispred, 6);
    lookup("walk.nt2", 32'h300, 1, 0, 32'h400);
    update(32'h300, 1, 0, 32'h400, 0);
    check("walk.t1_mispred", st_mispred, 7);
    lookup("walk.t1", 32'h300, 1, 0, 32'h400);
    update(32'h300, 1, 0, 32'h400, 0);
    check("walk.t2_mispred", st_mispred, 8);
    lookup("walk.t2", 32'h300, 1, 1, 32'h400);

    // Jump miss with upd_taken=0: allocates strong taken, evicts 0x108
    update(32'h600, 0, 1, 32'h700, 0);
    check("jump.mispred", st_mispred, 9);
    lookup("jump.600", 32'h600, 1, 1, 32'h700);
    lookup("jump.108", 32'h108, 0, 0, 0);
    lookup("jump.10C", 32'h10C, 1, 1, 32'h203);

    // Target change on a correctly predicted taken branch is a mispredict
    update(32'h100, 1, 0, 32'h250, 0);
    check("tgt.mispred", st_mispred, 10);
    lookup("tgt.100", 32'h100, 1, 1, 32'h250);

    // Flush with a simultaneous update: everything misses, nothing allocated
    update(32'h500, 0, 0, 32'h510, 1);
    check("flush.mispred", st_mispred, 10);
    lookup("flush.100", 32'h100, 0, 0, 0);
    lookup("flush.300", 32'h300, 0, 0, 0);
    lookup("flush.500", 32'h500, 0, 0, 0);
    lookup("flush.600", 32'h600, 0, 0, 0);
    lookup("flush.10C", 32'h10C, 0, 0, 0);

    // Refill after flush, then five hits; the 2-bit statistics stay at 3
    update(32'h800, 1, 0, 32'h900, 0);
    for (int i = 0; i < 5; i++) lookup("sat.800", 32'h800, 1, 1, 32'h900);
    check("sat.hits",     st_hits, 18);
    check("sat.s_hits",   ss_hits, 3);
    check("sat.s_lookups", ss_lookups, 3);
    check("sat.s_mispred", ss_mispred, 3);

    // Asynchronous reset between edges, with an update pending
    lk_pc = 32'h800; lk_valid = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h900; upd_taken = 1'b1; upd_jump = 1'b0;
    upd_target = 32'hA00;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.pred_hit",    pred_hit, 0);
    check("arst.pred_taken",  pred_taken, 0);
    check("arst.pred_target", pred_target, 0);
    check("arst.hits",        st_hits, 0);
    check("arst.mispred",     st_mispred, 0);
    check("arst.s_hits",      ss_hits, 0);
    step();
    upd_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    step();
    lookup("arst.800", 32'h800, 0, 0, 0);
    lookup("arst.900", 32'h900, 0, 0, 0);
    check("arst.lookups", st_lookups, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
